// File: rtl/rdl_apb_adapter.sv
// -----------------------------------------------------------------------------
// rdl_apb_adapter
//
// APB4 completer that turns each bus transfer into a single-cycle register
// strobe for the generated register block, then returns the registered read
// data / error response after a fixed latency (plus WaitStates extra cycles).
//
// Timing of one transfer (W = WaitStates):
//   setup cycle     : psel=1, penable=0 sampled in IDLE -> request captured
//   access cycle 1  : STROBE, reg_we or reg_re high, reg_rdata/reg_err sampled
//   access cycles 2..1+W : WAIT
//   access cycle 2+W: RESP, pready=1 with registered prdata/pslverr
//
// Parameters
//   AW         byte-address width of paddr / reg_addr
//   DW         data width (32 or 64); strobe width is DW/8
//   WaitStates extra wait cycles (0..15) between the strobe and pready
//
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   psel, penable, pwrite         APB control
//   paddr, pwdata, pstrb          APB address / write data / byte strobes
//   pready, prdata, pslverr       APB response (all registered)
//   reg_we, reg_re                one-cycle write / read strobes to decode
//   reg_addr, reg_wdata, reg_be   word-aligned address, write data, enables
//   reg_rdata, reg_err            read data and error from the decode mux
// -----------------------------------------------------------------------------
module rdl_apb_adapter #(
  parameter int unsigned AW         = 12,
  parameter int unsigned DW         = 32,
  parameter int unsigned WaitStates = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [AW-1:0]   paddr,
  input  logic [DW-1:0]   pwdata,
  input  logic [DW/8-1:0] pstrb,
  output logic            pready,
  output logic [DW-1:0]   prdata,
  output logic            pslverr,
  output logic            reg_we,
  output logic            reg_re,
  output logic [AW-1:0]   reg_addr,
  output logic [DW-1:0]   reg_wdata,
  output logic [DW/8-1:0] reg_be,
  input  logic [DW-1:0]   reg_rdata,
  input  logic            reg_err
);

  localparam int unsigned BW   = DW / 8;
  localparam int unsigned OFFW = $clog2(BW);

  // Only the low four bits of WaitStates are meaningful (range 0..15).
  localparam bit         HasWait  = (WaitStates > 32'd0);
  localparam logic [3:0] WaitLoad = HasWait ? 4'(WaitStates - 32'd1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // True when the byte-offset bits of an address are all zero.
  function automatic logic is_aligned(input logic [AW-1:0] a);
    return (a[OFFW-1:0] == {OFFW{1'b0}});
  endfunction

  // Address with the byte-offset bits forced to zero.
  function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] a);
    return {a[AW-1:OFFW], {OFFW{1'b0}}};
  endfunction

  state_e          state_q,     state_d;
  logic [3:0]      wait_cnt_q,  wait_cnt_d;
  logic            wr_q,        wr_d;
  logic            misalign_q,  misalign_d;
  logic            strobed_q,   strobed_d;
  logic [DW-1:0]   hold_data_q, hold_data_d;
  logic            hold_err_q,  hold_err_d;
  logic            pready_q,    pready_d;
  logic [DW-1:0]   prdata_q,    prdata_d;
  logic            pslverr_q,   pslverr_d;
  logic            reg_we_q,    reg_we_d;
  logic            reg_re_q,    reg_re_d;
  logic [AW-1:0]   reg_addr_q,  reg_addr_d;
  logic [DW-1:0]   reg_wdata_q, reg_wdata_d;
  logic [BW-1:0]   reg_be_q,    reg_be_d;

  logic [DW-1:0]   samp_data_s;
  logic            samp_err_s;

  // Response captured at the end of the STROBE cycle. A misaligned access
  // reports an error without ever strobing; reg_err only counts when a strobe
  // was actually issued (a pstrb==0 write never reaches decode).
  always_comb begin
    samp_err_s = misalign_q | (strobed_q & reg_err);
    if (!wr_q && strobed_q && !reg_err) begin
      samp_data_s = reg_rdata;
    end else begin
      samp_data_s = {DW{1'b0}};
    end
  end

  // Next-state and registered-output logic of the transfer FSM.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    wr_d        = wr_q;
    misalign_d  = misalign_q;
    strobed_d   = strobed_q;
    hold_data_d = hold_data_q;
    hold_err_d  = hold_err_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_be_d    = reg_be_q;
    // Strobes and the response are single-cycle pulses unless set below.
    pready_d    = 1'b0;
    prdata_d    = {DW{1'b0}};
    pslverr_d   = 1'b0;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Only a setup phase starts a transfer; penable=1 here is ignored.
        if (psel && !penable) begin
          wr_d       = pwrite;
          misalign_d = !is_aligned(paddr);
          reg_addr_d = word_addr(paddr);
          wait_cnt_d = 4'd0;
          if (pwrite) begin
            reg_wdata_d = pwdata;
            if (is_aligned(paddr)) begin
              reg_be_d = pstrb;
            end else begin
              reg_be_d = {BW{1'b0}};
            end
            strobed_d = is_aligned(paddr) && (pstrb != {BW{1'b0}});
            reg_we_d  = is_aligned(paddr) && (pstrb != {BW{1'b0}});
          end else begin
            reg_be_d  = {BW{1'b0}};
            strobed_d = is_aligned(paddr);
            reg_re_d  = is_aligned(paddr);
          end
          state_d = S_STROBE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_STROBE: begin
        hold_data_d = samp_data_s;
        hold_err_d  = samp_err_s;
        // Abort: the strobe already issued stands, but no response is given.
        if (!psel) begin
          state_d = S_IDLE;
        end else if (HasWait) begin
          wait_cnt_d = WaitLoad;
          state_d    = S_WAIT;
        end else begin
          pready_d  = 1'b1;
          prdata_d  = samp_data_s;
          pslverr_d = samp_err_s;
          state_d   = S_RESP;
        end
      end

      S_WAIT: begin
        if (!psel) begin
          wait_cnt_d = 4'd0;
          state_d    = S_IDLE;
        end else if (wait_cnt_q == 4'd0) begin
          pready_d  = 1'b1;
          prdata_d  = hold_data_q;
          pslverr_d = hold_err_q;
          state_d   = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
          state_d    = S_WAIT;
        end
      end

      S_RESP: begin
        // pready is high during this cycle; the master completes on this edge.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= 4'd0;
      wr_q        <= 1'b0;
      misalign_q  <= 1'b0;
      strobed_q   <= 1'b0;
      hold_data_q <= {DW{1'b0}};
      hold_err_q  <= 1'b0;
      pready_q    <= 1'b0;
      prdata_q    <= {DW{1'b0}};
      pslverr_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      reg_addr_q  <= {AW{1'b0}};
      reg_wdata_q <= {DW{1'b0}};
      reg_be_q    <= {BW{1'b0}};
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      wr_q        <= wr_d;
      misalign_q  <= misalign_d;
      strobed_q   <= strobed_d;
      hold_data_q <= hold_data_d;
      hold_err_q  <= hold_err_d;
      pready_q    <= pready_d;
      prdata_q    <= prdata_d;
      pslverr_q   <= pslverr_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_be_q    <= reg_be_d;
    end
  end

  assign pready    = pready_q;
  assign prdata    = prdata_q;
  assign pslverr   = pslverr_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_be    = reg_be_q;

endmodule

// File: tb/tb_rdl_apb_adapter.sv
// -----------------------------------------------------------------------------
// tb_rdl_apb_adapter
//
// Three adapters (WaitStates 0, 3, 2) each with its own psel, sharing the
// other APB inputs and a small register-decode model. Expected responses come
// from a word-array model of the register space and the transfer rules.
// -----------------------------------------------------------------------------
module tb_rdl_apb_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  psel_v;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] reg_rdata;
  logic        reg_err;

  logic [2:0]  pready_v;
  logic [2:0]  pslverr_v;
  logic [2:0]  we_v;
  logic [2:0]  re_v;
  logic [31:0] prdata_v  [3];
  logic [11:0] raddr_v   [3];
  logic [31:0] rwdata_v  [3];
  logic [3:0]  rbe_v     [3];

  int          tests = 0;
  int          fails = 0;
  int          cur   = 0;
  bit          err_inject = 1'b0;

  logic [31:0] env_mem   [512] = '{default: 32'h0};
  logic [31:0] model_mem [512] = '{default: 32'h0};
  logic [11:0] cur_addr;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rdl_apb_adapter #(
      .AW         (12),
      .DW         (32),
      .WaitStates ((g == 0) ? 0 : ((g == 1) ? 3 : 2))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .psel      (psel_v[g]),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .pready    (pready_v[g]),
      .prdata    (prdata_v[g]),
      .pslverr   (pslverr_v[g]),
      .reg_we    (we_v[g]),
      .reg_re    (re_v[g]),
      .reg_addr  (raddr_v[g]),
      .reg_wdata (rwdata_v[g]),
      .reg_be    (rbe_v[g]),
      .reg_rdata (reg_rdata),
      .reg_err   (reg_err)
    );
  end

  // Register decode stand-in: addresses >= 0x800 (or injected) are misses.
  always_comb begin
    cur_addr  = raddr_v[cur];
    reg_err   = (cur_addr >= 12'h800) || err_inject;
    reg_rdata = reg_err ? 32'h0 : env_mem[cur_addr[10:2]];
  end

  // Register writes land on the strobe, byte by byte.
  always @(posedge clk) begin
    if (we_v[cur] && !reg_err) begin
      for (int b = 0; b < 4; b++) begin
        if (rbe_v[cur][b]) env_mem[cur_addr[10:2]][8*b +: 8] <= rwdata_v[cur][8*b +: 8];
      end
    end
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [11:0] a, input logic [31:0] wd, input logic [3:0] st);
    for (int b = 0; b < 4; b++) begin
      if (st[b]) model_mem[a[10:2]][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic check_zero(input int k);
    check("rst_pready",  32'(pready_v[k]),  32'h0);
    check("rst_pslverr", 32'(pslverr_v[k]), 32'h0);
    check("rst_reg_we",  32'(we_v[k]),      32'h0);
    check("rst_reg_re",  32'(re_v[k]),      32'h0);
    check("rst_prdata",  prdata_v[k],       32'h0);
    check("rst_reg_addr", 32'(raddr_v[k]),  32'h0);
    check("rst_reg_wdata", rwdata_v[k],     32'h0);
    check("rst_reg_be",  32'(rbe_v[k]),     32'h0);
  endtask

  // One complete APB transfer on adapter k, checked against the rules.
  task automatic do_xfer(input int k, input bit wr, input logic [11:0] a,
                         input logic [31:0] wd, input logic [3:0] st, input bit inj);
    int          n;
    int          we_n;
    int          re_n;
    int          s_cyc;
    bit          got;
    bit          aligned;
    bit          dec_err;
    bit          strobe;
    bit          exp_err;
    logic [31:0] exp_rd;
    logic [31:0] rd;
    logic        err;
    logic [11:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wd;

    aligned = (a[1:0] == 2'b00);
    dec_err = (a >= 12'h800) || inj;
    strobe  = aligned && (!wr || (st != 4'h0));
    exp_err = !aligned || (strobe && dec_err);
    exp_rd  = (!wr && !exp_err) ? model_mem[a[10:2]] : 32'h0;

    cur        = k;
    err_inject = inj;
    psel_v     = 3'b000;
    psel_v[k]  = 1'b1;
    penable    = 1'b0;
    pwrite     = wr;
    paddr      = a;
    pwdata     = wd;
    pstrb      = st;
    tick();
    penable = 1'b1;

    n = 1; got = 1'b0; we_n = 0; re_n = 0; s_cyc = 0;
    rd = 32'h0; err = 1'b0; s_addr = 12'h0; s_be = 4'h0; s_wd = 32'h0;
    while (!got && n <= 40) begin
      if (we_v[k] || re_v[k]) begin
        s_cyc  = n;
        s_addr = raddr_v[k];
        s_be   = rbe_v[k];
        s_wd   = rwdata_v[k];
      end
      we_n += 32'(we_v[k]);
      re_n += 32'(re_v[k]);
      if (pready_v[k]) begin
        got = 1'b1;
        rd  = prdata_v[k];
        err = pslverr_v[k];
      end
      tick();
      if (!got) n++;
    end
    psel_v  = 3'b000;
    penable = 1'b0;
    err_inject = 1'b0;

    if (wr && strobe && !dec_err) model_write(a, wd, st);

    check("completed", 32'(got), 32'h1);
    check("latency", 32'(n), 32'(2 + ws_of(k)));
    check("pslverr", 32'(err), 32'(exp_err));
    check("prdata", rd, exp_rd);
    check("we_count", 32'(we_n), (wr && strobe) ? 32'h1 : 32'h0);
    check("re_count", 32'(re_n), (!wr && strobe) ? 32'h1 : 32'h0);
    if (strobe) begin
      check("strobe_cycle", 32'(s_cyc), 32'h1);
      check("reg_addr", 32'(s_addr), 32'({a[11:2], 2'b00}));
      check("reg_be", 32'(s_be), wr ? 32'(st) : 32'h0);
      if (wr) check("reg_wdata", s_wd, wd);
    end
  endtask

  initial begin
    int          cnt;
    int          k;
    int          r;
    bit          wr;
    bit          inj;
    logic [11:0] a;

    rst = 1'b0; psel_v = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = 12'h0; pwdata = 32'h0; pstrb = 4'h0;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) check_zero(i);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Directed transfers.
    do_xfer(0, 1'b1, 12'h010, 32'h0000_00A5, 4'hF, 1'b0);
    do_xfer(0, 1'b1, 12'h020, 32'hDEAD_BEEF, 4'hF, 1'b0);
    tick();
    do_xfer(1, 1'b0, 12'h020, 32'h0, 4'h0, 1'b0);
    check("read_deadbeef", model_mem[12'h020 >> 2], 32'hDEAD_BEEF);
    do_xfer(0, 1'b0, 12'h024, 32'h0, 4'hF, 1'b1);
    do_xfer(0, 1'b1, 12'h013, 32'h1234_5678, 4'hF, 1'b0);
    do_xfer(0, 1'b1, 12'h010, 32'hFFFF_FFFF, 4'h0, 1'b0);
    do_xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0);

    // penable=1 without a setup phase must be ignored.
    cur = 0; psel_v = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 12'h030; pstrb = 4'hF;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cnt += 32'(we_v[0]) + 32'(re_v[0]) + 32'(pready_v[0]);
    end
    check("idle_penable_ignored", 32'(cnt), 32'h0);
    psel_v = 3'b000; penable = 1'b0;
    tick();

    // Abort during WAIT on the W=2 adapter: the write stands, no pready.
    cur = 2; psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1;
    paddr = 12'h040; pwdata = 32'h5A5A_1234; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    check("abort_we_issued", 32'(we_v[2]), 32'h1);
    tick();
    psel_v = 3'b000; penable = 1'b0;
    model_write(12'h040, 32'h5A5A_1234, 4'hF);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cnt += 32'(pready_v[2]);
      tick();
    end
    check("abort_no_pready", 32'(cnt), 32'h0);
    do_xfer(2, 1'b0, 12'h040, 32'h0, 4'h0, 1'b0);

    // Reset asserted mid-WAIT on the W=3 adapter.
    cur = 1; psel_v = 3'b010; penable = 1'b0; pwrite = 1'b1;
    paddr = 12'h100; pwdata = 32'hCAFE_F00D; pstrb = 4'b0110;
    tick();
    penable = 1'b1;
    tick();
    #2;
    rst = 1'b0;
    #1;
    check_zero(1);
    psel_v = 3'b000; penable = 1'b0;
    model_write(12'h100, 32'hCAFE_F00D, 4'b0110);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cnt += 32'(pready_v[1]) + 32'(we_v[1]) + 32'(re_v[1]);
    end
    check("post_reset_idle", 32'(cnt), 32'h0);
    do_xfer(1, 1'b0, 12'h100, 32'h0, 4'h0, 1'b0);

    // Randomized transfers with random idle gaps (0 = back-to-back).
    for (int t = 0; t < 80; t++) begin
      k   = $urandom_range(0, 2);
      wr  = 1'($urandom_range(0, 1));
      r   = $urandom_range(0, 9);
      inj = 1'b0;
      if (r <= 5) begin
        a = 12'($urandom_range(0, 15) * 4);
      end else if (r <= 7) begin
        a = 12'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      end else if (r == 8) begin
        a = 12'(32'h800 + $urandom_range(0, 15) * 4);
      end else begin
        a   = 12'($urandom_range(0, 15) * 4);
        inj = 1'b1;
      end
      do_xfer(k, wr, a, $urandom, 4'($urandom_range(0, 15)), inj);
      r = $urandom_range(0, 2);
      for (int i = 0; i < r; i++) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
